// File: rtl/game_flow_ctrl_if.sv
// Signal bundle between the game-flow sequencer and the player/HUD side.
// master drives player status and keys; slave is the sequencer.
interface game_flow_ctrl_if #(
    parameter int N_PLAYERS = 2,
    parameter int LW        = 2,
    parameter int VW        = 2
);
    logic                 frame_tick;
    logic                 start;
    logic [N_PLAYERS-1:0] player_dead;
    logic [N_PLAYERS-1:0] player_win;
    logic [2:0]           state;
    logic [LW-1:0]        level;
    logic [VW-1:0]        lives;
    logic [9:0]           time_sec;
    logic                 revive;
    logic                 playing;

    modport master (
        output frame_tick, start, player_dead, player_win,
        input  state, level, lives, time_sec, revive, playing
    );

    modport slave (
        input  frame_tick, start, player_dead, player_win,
        output state, level, lives, time_sec, revive, playing
    );
endinterface

// File: rtl/game_flow_ctrl.sv
// Game-flow sequencer: lives, level progression, timed death/clear
// holds in video frames and an elapsed-seconds counter for the HUD.
module game_flow_ctrl #(
    parameter int N_PLAYERS    = 2,
    parameter int N_LEVELS     = 4,
    parameter int LIVES        = 3,
    parameter int DEATH_FRAMES = 90,
    parameter int WIN_FRAMES   = 120,
    parameter int FPS          = 60
) (
    input logic             Clk,
    input logic             Reset_n,
    game_flow_ctrl_if.slave bus
);
    localparam int LW   = (N_LEVELS > 1) ? $clog2(N_LEVELS) : 1;
    localparam int VW   = $clog2(LIVES + 1);
    localparam int SW   = (FPS > 1) ? $clog2(FPS) : 1;
    localparam int HMAX = (DEATH_FRAMES > WIN_FRAMES) ? DEATH_FRAMES
                                                      : WIN_FRAMES;
    localparam int HW   = $clog2(HMAX + 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        PLAY     = 3'd2,
        DYING    = 3'd3,
        CLEAR    = 3'd4,
        GAMEOVER = 3'd5,
        VICTORY  = 3'd6
    } state_t;

    state_t        state_q, state_d;
    logic [LW-1:0] level_q, level_d;
    logic [VW-1:0] lives_q, lives_d;
    logic [9:0]    time_q, time_d;
    logic [SW-1:0] sub_q, sub_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          start_q;
    logic          block_q;
    logic          start_edge;
    logic          any_dead;
    logic          all_win;

    // block_q masks a key already held when reset is released
    assign start_edge = bus.start & ~start_q & ~block_q;
    assign any_dead   = |bus.player_dead;
    assign all_win    = &bus.player_win;

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        lives_d = lives_q;
        time_d  = time_q;
        sub_d   = sub_q;
        hold_d  = hold_q;
        unique case (state_q)
            IDLE: begin
                if (start_edge) begin
                    state_d = LOAD;
                    level_d = '0;
                    lives_d = VW'(LIVES);
                end
            end
            LOAD: begin
                state_d = PLAY;
                time_d  = '0;
                sub_d   = '0;
                hold_d  = '0;
            end
            PLAY: begin
                if (bus.frame_tick) begin
                    if (sub_q == SW'(FPS - 1)) begin
                        sub_d = '0;
                        if (time_q != 10'd1023)
                            time_d = time_q + 1'b1;
                    end else begin
                        sub_d = sub_q + 1'b1;
                    end
                end
                if (any_dead)
                    state_d = DYING;
                else if (all_win)
                    state_d = CLEAR;
            end
            DYING: begin
                if (bus.frame_tick) begin
                    if (hold_q == HW'(DEATH_FRAMES - 1)) begin
                        if (lives_q == VW'(1)) begin
                            state_d = GAMEOVER;
                            lives_d = '0;
                        end else begin
                            state_d = LOAD;
                            lives_d = lives_q - 1'b1;
                        end
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end
            CLEAR: begin
                if (bus.frame_tick) begin
                    if (hold_q == HW'(WIN_FRAMES - 1)) begin
                        if (level_q == LW'(N_LEVELS - 1)) begin
                            state_d = VICTORY;
                        end else begin
                            state_d = LOAD;
                            level_d = level_q + 1'b1;
                        end
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end
            GAMEOVER, VICTORY: begin
                if (start_edge)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (state_d != state_q)
            hold_d = '0;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            level_q <= '0;
            lives_q <= VW'(LIVES);
            time_q  <= '0;
            sub_q   <= '0;
            hold_q  <= '0;
            start_q <= 1'b0;
            block_q <= 1'b1;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            lives_q <= lives_d;
            time_q  <= time_d;
            sub_q   <= sub_d;
            hold_q  <= hold_d;
            start_q <= bus.start;
            block_q <= block_q & bus.start;
        end
    end

    assign bus.state    = state_q;
    assign bus.level    = level_q;
    assign bus.lives    = lives_q;
    assign bus.time_sec = time_q;
    assign bus.revive   = (state_q == LOAD);
    assign bus.playing  = (state_q == PLAY);
endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: vector table plus hand sequences
// for timer saturation and reset during a clear hold.
module tb_game_flow_ctrl;
    localparam int S_IDLE = 0, S_LOAD = 1, S_PLAY = 2, S_DYING = 3;
    localparam int S_CLEAR = 4, S_OVER = 5, S_VIC = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    game_flow_ctrl_if #(.N_PLAYERS(2), .LW(2), .VW(2)) bus ();

    game_flow_ctrl dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    typedef struct {
        logic       s;
        logic       t;
        logic [1:0] d;
        logic [1:0] w;
        int         reps;
        int         st;
        int         lvl;
        int         lv;
        int         tm;
        int         rv;
        int         pl;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic s, input logic t,
                                input logic [1:0] d, input logic [1:0] w,
                                input int reps, input int st,
                                input int lvl, input int lv, input int tm,
                                input int rv, input int pl);
        vec_t v;
        v = '{s, t, d, w, reps, st, lvl, lv, tm, rv, pl};
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_all(input string tag, input int st, input int lvl,
                              input int lv, input int tm, input int rv,
                              input int pl);
        check({tag, ".state"}, int'(bus.state), st);
        check({tag, ".level"}, int'(bus.level), lvl);
        check({tag, ".lives"}, int'(bus.lives), lv);
        check({tag, ".time_sec"}, int'(bus.time_sec), tm);
        check({tag, ".revive"}, int'(bus.revive), rv);
        check({tag, ".playing"}, int'(bus.playing), pl);
    endtask

    task automatic apply(input logic s, input logic t, input logic [1:0] d,
                         input logic [1:0] w, input int reps);
        bus.start       = s;
        bus.frame_tick  = t;
        bus.player_dead = d;
        bus.player_win  = w;
        repeat (reps) @(posedge clk);
        #1;
    endtask

    initial begin
        bus.start       = 1'b0;
        bus.frame_tick  = 1'b0;
        bus.player_dead = 2'b00;
        bus.player_win  = 2'b00;

        // start, timer, three deaths, game over
        add(0, 0, 2'b00, 2'b00, 1, S_IDLE, 0, 3, 0, 0, 0);
        add(1, 0, 2'b00, 2'b00, 1, S_LOAD, 0, 3, 0, 1, 0);
        add(1, 0, 2'b00, 2'b00, 1, S_PLAY, 0, 3, 0, 0, 1);
        add(0, 1, 2'b00, 2'b00, 59, S_PLAY, 0, 3, 0, 0, 1);
        add(0, 1, 2'b00, 2'b00, 1, S_PLAY, 0, 3, 1, 0, 1);
        add(0, 1, 2'b00, 2'b00, 65, S_PLAY, 0, 3, 2, 0, 1);
        add(0, 0, 2'b00, 2'b10, 3, S_PLAY, 0, 3, 2, 0, 1);
        add(1, 0, 2'b00, 2'b00, 1, S_PLAY, 0, 3, 2, 0, 1);
        add(0, 0, 2'b00, 2'b00, 1, S_PLAY, 0, 3, 2, 0, 1);
        add(0, 1, 2'b01, 2'b11, 1, S_DYING, 0, 3, 2, 0, 0);
        add(0, 1, 2'b00, 2'b00, 89, S_DYING, 0, 3, 2, 0, 0);
        add(0, 1, 2'b00, 2'b00, 1, S_LOAD, 0, 2, 2, 1, 0);
        add(0, 0, 2'b00, 2'b00, 1, S_PLAY, 0, 2, 0, 0, 1);
        add(0, 0, 2'b10, 2'b00, 1, S_DYING, 0, 2, 0, 0, 0);
        add(1, 1, 2'b00, 2'b00, 1, S_DYING, 0, 2, 0, 0, 0);
        add(0, 1, 2'b00, 2'b00, 89, S_LOAD, 0, 1, 0, 1, 0);
        add(0, 0, 2'b00, 2'b00, 1, S_PLAY, 0, 1, 0, 0, 1);
        add(0, 0, 2'b11, 2'b00, 1, S_DYING, 0, 1, 0, 0, 0);
        add(0, 1, 2'b00, 2'b00, 89, S_DYING, 0, 1, 0, 0, 0);
        add(0, 1, 2'b00, 2'b00, 1, S_OVER, 0, 0, 0, 0, 0);
        add(0, 1, 2'b00, 2'b00, 3, S_OVER, 0, 0, 0, 0, 0);
        add(1, 0, 2'b00, 2'b00, 1, S_IDLE, 0, 0, 0, 0, 0);
        add(0, 0, 2'b00, 2'b00, 1, S_IDLE, 0, 0, 0, 0, 0);
        add(1, 0, 2'b00, 2'b00, 1, S_LOAD, 0, 3, 0, 1, 0);
        add(0, 0, 2'b00, 2'b00, 1, S_PLAY, 0, 3, 0, 0, 1);
        // clear all four levels
        for (int l = 0; l < 4; l++) begin
            add(0, 0, 2'b00, 2'b11, 1, S_CLEAR, l, 3, 0, 0, 0);
            add(0, 1, 2'b00, 2'b00, 119, S_CLEAR, l, 3, 0, 0, 0);
            if (l < 3) begin
                add(0, 1, 2'b00, 2'b00, 1, S_LOAD, l + 1, 3, 0, 1, 0);
                add(0, 0, 2'b00, 2'b00, 1, S_PLAY, l + 1, 3, 0, 0, 1);
            end else begin
                add(0, 1, 2'b00, 2'b00, 1, S_VIC, 3, 3, 0, 0, 0);
            end
        end
        add(0, 1, 2'b00, 2'b11, 2, S_VIC, 3, 3, 0, 0, 0);
        add(1, 0, 2'b00, 2'b00, 1, S_IDLE, 3, 3, 0, 0, 0);
        add(0, 0, 2'b00, 2'b00, 1, S_IDLE, 3, 3, 0, 0, 0);
        add(1, 0, 2'b00, 2'b00, 1, S_LOAD, 0, 3, 0, 1, 0);
        add(0, 0, 2'b00, 2'b00, 1, S_PLAY, 0, 3, 0, 0, 1);

        repeat (3) @(posedge clk);
        #1;
        expect_all("reset", S_IDLE, 0, 3, 0, 0, 0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].s, vecs[i].t, vecs[i].d, vecs[i].w, vecs[i].reps);
            expect_all($sformatf("row%0d", i), vecs[i].st, vecs[i].lvl,
                       vecs[i].lv, vecs[i].tm, vecs[i].rv, vecs[i].pl);
        end

        // seconds counter saturation
        apply(0, 1, 2'b00, 2'b00, 61379);
        expect_all("sat_1022", S_PLAY, 0, 3, 1022, 0, 1);
        apply(0, 1, 2'b00, 2'b00, 1);
        expect_all("sat_1023", S_PLAY, 0, 3, 1023, 0, 1);
        apply(0, 1, 2'b00, 2'b00, 120);
        expect_all("sat_hold", S_PLAY, 0, 3, 1023, 0, 1);

        // reach level 1, then reset in the middle of its clear hold
        apply(0, 0, 2'b00, 2'b11, 1);
        expect_all("clr0", S_CLEAR, 0, 3, 1023, 0, 0);
        apply(0, 1, 2'b00, 2'b00, 120);
        expect_all("load1", S_LOAD, 1, 3, 1023, 1, 0);
        apply(0, 0, 2'b00, 2'b00, 1);
        expect_all("play1", S_PLAY, 1, 3, 0, 0, 1);
        apply(0, 0, 2'b00, 2'b11, 1);
        apply(0, 1, 2'b00, 2'b00, 50);
        expect_all("clr1", S_CLEAR, 1, 3, 0, 0, 0);
        bus.start      = 1'b1;
        bus.frame_tick = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        expect_all("async_rst", S_IDLE, 0, 3, 0, 0, 0);
        #3 rst_n = 1'b1;
        apply(1, 0, 2'b00, 2'b00, 3);
        expect_all("held_start", S_IDLE, 0, 3, 0, 0, 0);
        apply(0, 0, 2'b00, 2'b00, 1);
        expect_all("released", S_IDLE, 0, 3, 0, 0, 0);
        apply(1, 0, 2'b00, 2'b00, 1);
        expect_all("repress", S_LOAD, 0, 3, 0, 1, 0);
        apply(0, 0, 2'b00, 2'b00, 1);
        expect_all("replay", S_PLAY, 0, 3, 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
